// File: rtl/serial_tx_scheduler.sv
// -----------------------------------------------------------------------------
// serial_tx_scheduler
//
// Purpose:
//   Two requesters share one 8N1-style serial line. When the line is idle, a
//   round-robin arbiter picks a requester and captures its byte. The byte is
//   then sent as a frame: one start bit (0), eight data bits LSB first, and one
//   stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (2..65535)
//
// Ports:
//   Clock  in   single clock, all state changes on its rising edge
//   Reset  in   synchronous active-high reset
//   Req0   in   transmit request from requester 0 (CPU port)
//   Data0  in   [7:0] byte offered by requester 0
//   Ack0   out  one-cycle capture acknowledge to requester 0
//   Req1   in   transmit request from requester 1 (debug port)
//   Data1  in   [7:0] byte offered by requester 1
//   Ack1   out  one-cycle capture acknowledge to requester 1
//   Dout   out  shared serial line, idles high
//   Busy   out  high while a frame is being sent
//   Grant  out  index of the requester whose byte is being / was last sent
// -----------------------------------------------------------------------------
module serial_tx_scheduler #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Req0,
  input  logic [7:0] Data0,
  output logic       Ack0,
  input  logic       Req1,
  input  logic [7:0] Data1,
  output logic       Ack1,
  output logic       Dout,
  output logic       Busy,
  output logic       Grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

  localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);

  txState_t    state, stateNext;
  logic [15:0] bitCnt, bitCntNext;
  logic [2:0]  bitIdx, bitIdxNext;
  logic [7:0]  shiftReg, shiftRegNext;
  logic        doutNext;
  logic        busyNext;
  logic        ack0Next, ack1Next;
  logic        grantNext;
  logic        lastServed, lastServedNext;
  logic        bitDone;
  logic        pickOne;

  // The current bit time ends on the last tick of the bit-time counter.
  // Requester 1 wins when it is the only one asking, or when both ask and
  // requester 0 was the one served last.
  always_comb begin
    bitDone = (bitCnt == LAST_TICK);
    pickOne = Req1 && (!Req0 || (lastServed == 1'b0));
  end

  // Next-state and next-output logic. Every register has its next value
  // computed here so that all outputs come straight out of flops. Requests
  // are only looked at in IDLE, and the byte lives in shiftReg from capture
  // onward, so later changes on Data0/Data1 cannot disturb a frame in flight.
  always_comb begin
    stateNext      = state;
    bitCntNext     = bitCnt + 16'd1;
    bitIdxNext     = bitIdx;
    shiftRegNext   = shiftReg;
    doutNext       = Dout;
    busyNext       = Busy;
    ack0Next       = 1'b0;
    ack1Next       = 1'b0;
    grantNext      = Grant;
    lastServedNext = lastServed;

    case (state)
      IDLE: begin
        bitCntNext = 16'd0;
        bitIdxNext = 3'd0;
        doutNext   = 1'b1;
        busyNext   = 1'b0;
        if (Req0 || Req1) begin
          stateNext      = START;
          doutNext       = 1'b0;
          busyNext       = 1'b1;
          grantNext      = pickOne;
          lastServedNext = pickOne;
          shiftRegNext   = pickOne ? Data1 : Data0;
          ack0Next       = !pickOne;
          ack1Next       = pickOne;
        end
      end

      START: begin
        if (bitDone) begin
          stateNext    = DATA;
          bitCntNext   = 16'd0;
          bitIdxNext   = 3'd0;
          doutNext     = shiftReg[0];
          shiftRegNext = {1'b0, shiftReg[7:1]};
        end
      end

      DATA: begin
        if (bitDone) begin
          bitCntNext = 16'd0;
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
            doutNext  = 1'b1;
          end else begin
            bitIdxNext   = bitIdx + 3'd1;
            doutNext     = shiftReg[0];
            shiftRegNext = {1'b0, shiftReg[7:1]};
          end
        end
      end

      STOP: begin
        if (bitDone) begin
          stateNext  = IDLE;
          bitCntNext = 16'd0;
          busyNext   = 1'b0;
          doutNext   = 1'b1;
        end
      end

      default: begin
        stateNext  = IDLE;
        bitCntNext = 16'd0;
        busyNext   = 1'b0;
        doutNext   = 1'b1;
      end
    endcase
  end

  // State and output registers. Reset wins over any request on the same edge
  // and simply drops whatever frame was in progress; the pointer comes up as
  // "requester 1 served last" so requester 0 takes the first tie.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      bitCnt     <= 16'd0;
      bitIdx     <= 3'd0;
      shiftReg   <= 8'd0;
      Dout       <= 1'b1;
      Busy       <= 1'b0;
      Ack0       <= 1'b0;
      Ack1       <= 1'b0;
      Grant      <= 1'b0;
      lastServed <= 1'b1;
    end else begin
      state      <= stateNext;
      bitCnt     <= bitCntNext;
      bitIdx     <= bitIdxNext;
      shiftReg   <= shiftRegNext;
      Dout       <= doutNext;
      Busy       <= busyNext;
      Ack0       <= ack0Next;
      Ack1       <= ack1Next;
      Grant      <= grantNext;
      lastServed <= lastServedNext;
    end
  end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_scheduler
//
// Purpose:
//   Directed self-checking bench for serial_tx_scheduler. Instance dutA runs
//   with CLKS_PER_BIT=4 and instance dutB with CLKS_PER_BIT=2. Expected frame
//   levels are built from the frame format: start 0, data LSB first, stop 1.
// -----------------------------------------------------------------------------
module tb_serial_tx_scheduler;

  logic       clock = 1'b0;

  logic       reset, req0, req1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, dout, busy, grant;

  logic       resetB, req0B, req1B;
  logic [7:0] data0B, data1B;
  logic       ack0B, ack1B, doutB, busyB, grantB;

  int total = 0;
  int bad   = 0;

  // Free-running 10-unit clock shared by both instances.
  always #5 clock = ~clock;

  serial_tx_scheduler #(.CLKS_PER_BIT(4)) dutA (
    .Clock(clock), .Reset(reset),
    .Req0(req0), .Data0(data0), .Ack0(ack0),
    .Req1(req1), .Data1(data1), .Ack1(ack1),
    .Dout(dout), .Busy(busy), .Grant(grant)
  );

  serial_tx_scheduler #(.CLKS_PER_BIT(2)) dutB (
    .Clock(clock), .Reset(resetB),
    .Req0(req0B), .Data0(data0B), .Ack0(ack0B),
    .Req1(req1B), .Data1(data1B), .Ack1(ack1B),
    .Dout(doutB), .Busy(busyB), .Grant(grantB)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock edge and settle just after it, so checks never race it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive the dutA request inputs.
  task automatic applyStimulus(input logic r0, input logic [7:0] d0,
                               input logic r1, input logic [7:0] d1);
    req0  = r0;
    data0 = d0;
    req1  = r1;
    data1 = d1;
  endtask

  // One-cycle synchronous reset pulse on dutA.
  task automatic pulseReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Called in the cycle right after a capture edge on dutA. Walks all 40
  // frame cycles checking the line level, Busy, Grant and both Acks, then
  // checks the idle cycle that follows. Data0 can be overwritten at cycle
  // changeAt to show the frame in flight does not notice.
  task automatic observeFrame(input logic [7:0] bits, input logic expGrant,
                              input int changeAt, input logic [7:0] newData0);
    logic expBit;
    for (int c = 0; c < 40; c++) begin
      if (c == changeAt) data0 = newData0;
      if (c < 4)       expBit = 1'b0;
      else if (c < 36) expBit = bits[(c - 4) / 4];
      else             expBit = 1'b1;
      checkOutput($sformatf("dout@%0d", c), 16'(dout), 16'(expBit));
      checkOutput($sformatf("busy@%0d", c), 16'(busy), 16'd1);
      checkOutput($sformatf("grant@%0d", c), 16'(grant), 16'(expGrant));
      checkOutput($sformatf("ack0@%0d", c), 16'(ack0), 16'(c == 0 && expGrant == 1'b0));
      checkOutput($sformatf("ack1@%0d", c), 16'(ack1), 16'(c == 0 && expGrant == 1'b1));
      tick();
    end
    checkOutput("busyAfterFrame", 16'(busy), 16'd0);
    checkOutput("doutAfterFrame", 16'(dout), 16'd1);
  endtask

  // Directed test sequence.
  initial begin
    int found;

    reset  = 1'b1;
    applyStimulus(1'b1, 8'h12, 1'b1, 8'h34);
    resetB = 1'b1;
    req0B  = 1'b0;
    req1B  = 1'b0;
    data0B = 8'h00;
    data1B = 8'h00;

    // Reset dominates simultaneous requests for as long as it is held.
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("rstDout", 16'(dout), 16'd1);
      checkOutput("rstBusy", 16'(busy), 16'd0);
      checkOutput("rstAck0", 16'(ack0), 16'd0);
      checkOutput("rstAck1", 16'(ack1), 16'd0);
      checkOutput("rstGrant", 16'(grant), 16'd0);
    end

    // First tie after reset goes to requester 0.
    reset = 1'b0;
    tick();
    checkOutput("firstTieAck0", 16'(ack0), 16'd1);
    checkOutput("firstTieAck1", 16'(ack1), 16'd0);
    checkOutput("firstTieGrant", 16'(grant), 16'd0);
    checkOutput("firstTieBusy", 16'(busy), 16'd1);
    checkOutput("firstTieDout", 16'(dout), 16'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    pulseReset();

    // Single requester 0 frame carrying 0x55.
    applyStimulus(1'b1, 8'h55, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 8'h55, 1'b0, 8'h00);
    observeFrame(8'h55, 1'b0, -1, 8'h55);

    // Both requesters held: frames alternate 0,1,0,1, starts 41 cycles apart.
    pulseReset();
    applyStimulus(1'b1, 8'hA5, 1'b1, 8'h3C);
    for (int f = 0; f < 4; f++) begin
      tick();
      if (f % 2 == 0) observeFrame(8'hA5, 1'b0, -1, 8'hA5);
      else            observeFrame(8'h3C, 1'b1, -1, 8'hA5);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);

    // Reset during data bit 3 of a requester 1 frame aborts it for good.
    pulseReset();
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h3C);
    tick();
    checkOutput("abortAck1", 16'(ack1), 16'd1);
    checkOutput("abortGrant", 16'(grant), 16'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h3C);
    repeat (17) tick();
    checkOutput("abortBit3", 16'(dout), 16'd1);
    checkOutput("abortBusyBefore", 16'(busy), 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abortDout", 16'(dout), 16'd1);
    checkOutput("abortBusy", 16'(busy), 16'd0);
    checkOutput("abortGrantRst", 16'(grant), 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("abortNoResendBusy", 16'(busy), 16'd0);
      checkOutput("abortNoResendDout", 16'(dout), 16'd1);
      checkOutput("abortNoAck1", 16'(ack1), 16'd0);
    end
    applyStimulus(1'b1, 8'h11, 1'b1, 8'h22);
    tick();
    checkOutput("afterAbortAck0", 16'(ack0), 16'd1);
    checkOutput("afterAbortAck1", 16'(ack1), 16'd0);
    checkOutput("afterAbortGrant", 16'(grant), 16'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);

    // Data0 rewritten two cycles after Ack0 must not alter the frame.
    pulseReset();
    applyStimulus(1'b1, 8'h0F, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 8'h0F, 1'b0, 8'h00);
    observeFrame(8'h0F, 1'b0, 2, 8'hF0);

    // dutB: requester 1 raised mid-frame is acked 21 cycles after frame start.
    tick();
    resetB = 1'b0;
    req0B  = 1'b1;
    data0B = 8'h81;
    tick();
    checkOutput("bAck0", 16'(ack0B), 16'd1);
    checkOutput("bBusy", 16'(busyB), 16'd1);
    req0B = 1'b0;
    found = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 1) begin
        req1B  = 1'b1;
        data1B = 8'h5A;
      end
      tick();
      if (ack1B && found < 0) found = k;
      if (found >= 0) break;
    end
    checkOutput("bAck1Delay", 16'(found), 16'd21);
    checkOutput("bAck1Grant", 16'(grantB), 16'd1);
    req1B = 1'b0;
    tick();
    checkOutput("bAck1Width", 16'(ack1B), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
